// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready flow control and a 2-entry skid buffer.
// The main register drives the outputs and the skid register absorbs the one beat that arrives while downstream stalls.
module pipe_stage_skid #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 133,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              in_ready_q;
    logic              vld_p1;

    logic [CTRL_W-1:0] main_ctrl_p1;
    logic [DATA_W-1:0] main_data_p1;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic [DATA_W-1:0] skid_data_p1;

    logic              in_fire;
    logic              out_fire;
    logic              main_load_in;
    logic              main_load_skid;
    logic              main_clear;
    logic              skid_load_in;
    logic              skid_clear;

    assign vld_p1      = (state_q != EMPTY);
    assign in_fire     = in_valid_i & in_ready_q;
    assign out_fire    = vld_p1 & out_ready_i;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = vld_p1;
    assign out_ctrl_o  = main_ctrl_p1;
    assign out_data_o  = main_data_p1;
    assign count_o     = state_q;

    // Next-state and register-steering decisions; flush overrides every handshake.
    always_comb begin
        state_d        = state_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load_in   = 1'b0;
        skid_clear     = 1'b0;

        if (flush_i) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = HALF;
                        main_load_in = 1'b1;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_load_in = 1'b1;
                    end else if (in_fire) begin
                        state_d      = FULL;
                        skid_load_in = 1'b1;
                    end else if (out_fire) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move
                    if (out_fire) begin
                        state_d        = HALF;
                        main_load_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // State register; in_ready is registered from the next state so it has no path from out_ready_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Control bundle: always zeroed when its entry dies so a killed beat has no side effects.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_ctrl_p1 <= '0;
            skid_ctrl_p1 <= '0;
        end else begin
            if (main_load_in)
                main_ctrl_p1 <= in_ctrl_i;
            else if (main_load_skid)
                main_ctrl_p1 <= skid_ctrl_p1;
            else if (main_clear)
                main_ctrl_p1 <= '0;

            if (skid_load_in)
                skid_ctrl_p1 <= in_ctrl_i;
            else if (skid_clear)
                skid_ctrl_p1 <= '0;
        end
    end

    // Data bundle: dead entries keep stale contents unless CLEAR_DATA asks for zeroing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_data_p1 <= '0;
            skid_data_p1 <= '0;
        end else begin
            if (main_load_in)
                main_data_p1 <= in_data_i;
            else if (main_load_skid)
                main_data_p1 <= skid_data_p1;
            else if (main_clear && CLEAR_DATA)
                main_data_p1 <= '0;

            if (skid_load_in)
                skid_data_p1 <= in_data_i;
            else if (skid_clear && CLEAR_DATA)
                skid_data_p1 <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (stale data / cleared data) share stimulus and are
// compared against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 133;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    logic              in_ready  [2];
    logic              out_valid [2];
    logic [CTRL_W-1:0] out_ctrl  [2];
    logic [DATA_W-1:0] out_data  [2];
    logic [1:0]        count     [2];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl[0]), .out_data_o(out_data[0]), .count_o(count[0])
    );

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl[1]), .out_data_o(out_data[1]), .count_o(count[1])
    );

    // One clock edge: the model is a FIFO of capacity 2 that accepts whenever it is not full.
    task automatic tick();
        bit fin;
        bit fout;
        fin  = in_valid && (q.size() < 2);
        fout = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (fout) void'(q.pop_front());
            if (fin)  q.push_back('{c: in_ctrl, d: in_data});
        end
        #1;
    endtask

    // {valid, ready, count, ctrl} the stage should present for the current model contents.
    function automatic logic [11:0] exp_status();
        logic [CTRL_W-1:0] c;
        c = (q.size() > 0) ? q[0].c : '0;
        return {q.size() > 0, q.size() < 2, 2'(q.size()), c};
    endfunction

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks += 5;
            if (out_valid[k] !== 1'b0) begin
                n_errors++; $display("FAIL reset_valid dut%0d: got %b expected 0", k, out_valid[k]);
            end
            if (in_ready[k] !== 1'b1) begin
                n_errors++; $display("FAIL reset_ready dut%0d: got %b expected 1", k, in_ready[k]);
            end
            if (count[k] !== 2'd0) begin
                n_errors++; $display("FAIL reset_count dut%0d: got %0d expected 0", k, count[k]);
            end
            if (out_ctrl[k] !== '0) begin
                n_errors++; $display("FAIL reset_ctrl dut%0d: got %h expected 0", k, out_ctrl[k]);
            end
            if (out_data[k] !== '0) begin
                n_errors++; $display("FAIL reset_data dut%0d: got %h expected 0", k, out_data[k]);
            end
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'hA5;
            in_data  = DATA_W'(i);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks += 3;
                if ({out_valid[k], in_ready[k], count[k], out_ctrl[k]} !== exp_status()) begin
                    n_errors++;
                    $display("FAIL stream_status dut%0d beat %0d: got %h expected %h", k, i,
                             {out_valid[k], in_ready[k], count[k], out_ctrl[k]}, exp_status());
                end
                if (out_data[k] !== DATA_W'(i)) begin
                    n_errors++; $display("FAIL stream_data dut%0d: got %0d expected %0d", k, out_data[k], i);
                end
                if (count[k] > 2'd1) begin
                    n_errors++; $display("FAIL stream_count dut%0d: got %0d expected <=1", k, count[k]);
                end
            end
        end
        idle_inputs();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (out_valid[k] !== 1'b0 || count[k] !== 2'd0) begin
                n_errors++;
                $display("FAIL stream_drain dut%0d: got valid %b count %0d expected 0 0", k, out_valid[k], count[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int stim_d[6] = '{3, 4, 5, 5, 5, 0};
        bit stim_v[6] = '{1, 1, 1, 1, 1, 0};
        bit stim_r[6] = '{0, 0, 0, 1, 1, 1};
        int exp_d[6]  = '{3, 3, 3, 4, 5, 0};
        int exp_c[6]  = '{1, 2, 2, 1, 1, 0};
        for (int s = 0; s < 6; s++) begin
            in_valid  = stim_v[s];
            in_ctrl   = 8'h5A;
            in_data   = DATA_W'(stim_d[s]);
            out_ready = stim_r[s];
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks += 2;
                if (count[k] !== 2'(exp_c[s]) || in_ready[k] !== (exp_c[s] != 2)
                    || out_valid[k] !== (exp_c[s] != 0)) begin
                    n_errors++;
                    $display("FAIL bp_occupancy dut%0d step %0d: got count %0d ready %b valid %b expected count %0d",
                             k, s, count[k], in_ready[k], out_valid[k], exp_c[s]);
                end
                if (exp_c[s] != 0 && out_data[k] !== DATA_W'(exp_d[s])) begin
                    n_errors++;
                    $display("FAIL bp_order dut%0d step %0d: got %0d expected %0d", k, s, out_data[k], exp_d[s]);
                end else if ({out_valid[k], in_ready[k], count[k], out_ctrl[k]} !== exp_status()) begin
                    n_errors++;
                    $display("FAIL bp_model dut%0d step %0d: got %h expected %h", k, s,
                             {out_valid[k], in_ready[k], count[k], out_ctrl[k]}, exp_status());
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h3C;
        in_data   = DATA_W'(10);
        tick();
        in_data   = DATA_W'(11);
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (count[k] !== 2'd2) begin
                n_errors++; $display("FAIL flush_prefill dut%0d: got count %0d expected 2", k, count[k]);
            end
        end
        flush   = 1'b1;
        in_data = DATA_W'(12);
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({out_valid[k], in_ready[k], count[k], out_ctrl[k]} !== {1'b0, 1'b1, 2'd0, 8'h00}) begin
                n_errors++;
                $display("FAIL flush_full dut%0d: got %h expected %h", k,
                         {out_valid[k], in_ready[k], count[k], out_ctrl[k]}, {1'b0, 1'b1, 2'd0, 8'h00});
            end
        end
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (out_valid[k] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL flush_discard dut%0d: got valid %b data %0d expected valid 0", k, out_valid[k], out_data[k]);
                end
            end
        end
    endtask

    task automatic test_clear_data();
        logic [DATA_W-1:0] dead;
        dead = DATA_W'(32'hDEAD);
        // flush path
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = dead;
        tick();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks += 4;
        if (out_data[0] !== dead) begin
            n_errors++; $display("FAIL keep_data_flush: got %h expected %h", out_data[0], dead);
        end
        if (out_data[1] !== '0) begin
            n_errors++; $display("FAIL clear_data_flush: got %h expected 0", out_data[1]);
        end
        if (out_ctrl[0] !== '0 || out_ctrl[1] !== '0) begin
            n_errors++; $display("FAIL ctrl_flush: got %h/%h expected 00/00", out_ctrl[0], out_ctrl[1]);
        end
        // drain path
        in_valid = 1'b1;
        in_ctrl  = 8'h81;
        in_data  = dead;
        out_ready = 1'b1;
        tick();
        idle_inputs();
        tick();
        if (out_data[0] !== dead) begin
            n_errors++; $display("FAIL keep_data_drain: got %h expected %h", out_data[0], dead);
        end
        n_checks += 2;
        if (out_data[1] !== '0) begin
            n_errors++; $display("FAIL clear_data_drain: got %h expected 0", out_data[1]);
        end
        if (out_ctrl[0] !== '0 || out_ctrl[1] !== '0) begin
            n_errors++; $display("FAIL ctrl_drain: got %h/%h expected 00/00", out_ctrl[0], out_ctrl[1]);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h77;
        in_data   = DATA_W'(32'h1234);
        tick();
        in_data   = DATA_W'(32'h5678);
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (count[k] !== 2'd2) begin
                n_errors++; $display("FAIL rstflush_prefill dut%0d: got count %0d expected 2", k, count[k]);
            end
        end
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({out_valid[k], in_ready[k], count[k], out_ctrl[k], out_data[k]} !==
                {1'b0, 1'b1, 2'd0, 8'h00, {DATA_W{1'b0}}}) begin
                n_errors++;
                $display("FAIL rstflush dut%0d: got valid %b ready %b count %0d ctrl %h data %h expected 0 1 0 00 0",
                         k, out_valid[k], in_ready[k], count[k], out_ctrl[k], out_data[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 149) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid) begin
                in_ctrl = CTRL_W'($urandom);
                in_data = DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
            end else begin
                in_ctrl = 'x;
                in_data = 'x;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({out_valid[k], in_ready[k], count[k], out_ctrl[k]} !== exp_status()) begin
                    n_errors++;
                    $display("FAIL rand_status dut%0d cyc %0d: got %h expected %h", k, n,
                             {out_valid[k], in_ready[k], count[k], out_ctrl[k]}, exp_status());
                end
                if (q.size() > 0) begin
                    n_checks++;
                    if (out_data[k] !== q[0].d) begin
                        n_errors++;
                        $display("FAIL rand_data dut%0d cyc %0d: got %h expected %h", k, n, out_data[k], q[0].d);
                    end
                end else if (k == 1) begin
                    n_checks++;
                    if (out_data[1] !== '0) begin
                        n_errors++;
                        $display("FAIL rand_cleared dut1 cyc %0d: got %h expected 0", n, out_data[1]);
                    end
                end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_clear_data();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
